// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode sequencer for the multi-cycle RV32I core: owns the PC, handshakes with imem,
// holds the fetched word for the decoder and raises traps. Optional macro: IFETCH_ALIGN_CHECK_EN.
module fetch_decode_ctrl #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        dec_en,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   input  logic        dec_invalid,
   input  logic        exe_ready,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic        trap_valid,
   output logic [1:0]  trap_cause,
   output logic [31:0] trap_pc
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_TRAP   = 2'd2
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [31:0]       pc_r, pc_nxt_s;
   logic [31:0]       ir_r, ir_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic              imem_req_r, dec_en_r, trap_valid_r;
   logic [1:0]        trap_cause_r, trap_cause_nxt_s;
   logic [31:0]       trap_pc_r, trap_pc_nxt_s;
   logic              redir_misaligned_s;
   logic [31:0]       redir_target_s;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign redir_misaligned_s = (redirect_addr[1:0] != 2'b00);
   assign redir_target_s     = redirect_addr;
`else
   assign redir_misaligned_s = 1'b0;
   assign redir_target_s     = redirect_addr & 32'hFFFF_FFFC;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; a FETCH cycle only counts once the request is actually on the bus
   always_comb begin
      state_nxt_s = state_r;
      if (redirect_valid) begin
         state_nxt_s = redir_misaligned_s ? ST_TRAP : ST_FETCH;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (!imem_req_r)            state_nxt_s = ST_FETCH;
               else if (imem_ack)          state_nxt_s = ST_DECODE;
               else if (cnt_r == CNT_LAST) state_nxt_s = ST_TRAP;
               else                        state_nxt_s = ST_FETCH;
            end
            ST_DECODE: begin
               if (stall)            state_nxt_s = ST_DECODE;
               else if (dec_invalid) state_nxt_s = ST_TRAP;
               else if (exe_ready)   state_nxt_s = ST_FETCH;
               else                  state_nxt_s = ST_DECODE;
            end
            ST_TRAP:  state_nxt_s = ST_TRAP;
            default:  state_nxt_s = ST_FETCH;
         endcase
      end
   end

   // Datapath and trap-record next values
   always_comb begin
      pc_nxt_s         = pc_r;
      ir_nxt_s         = ir_r;
      cnt_nxt_s        = cnt_r;
      trap_cause_nxt_s = trap_cause_r;
      trap_pc_nxt_s    = trap_pc_r;
      if (redirect_valid) begin
         cnt_nxt_s = {CNT_W{1'b0}};
         if (redir_misaligned_s) begin
            trap_cause_nxt_s = 2'b11;
            trap_pc_nxt_s    = redirect_addr;
         end else begin
            pc_nxt_s         = redir_target_s;
            trap_cause_nxt_s = 2'b00;
            trap_pc_nxt_s    = 32'h0000_0000;
         end
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (!imem_req_r) begin
                  cnt_nxt_s = cnt_r;
               end else if (imem_ack) begin
                  ir_nxt_s  = imem_rdata;
                  cnt_nxt_s = {CNT_W{1'b0}};
               end else if (cnt_r == CNT_LAST) begin
                  cnt_nxt_s        = {CNT_W{1'b0}};
                  trap_cause_nxt_s = 2'b10;
                  trap_pc_nxt_s    = pc_r;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end
            ST_DECODE: begin
               if (stall) begin
                  pc_nxt_s = pc_r;
               end else if (dec_invalid) begin
                  trap_cause_nxt_s = 2'b01;
                  trap_pc_nxt_s    = pc_r;
               end else if (exe_ready) begin
                  pc_nxt_s = pc_r + 32'd4;
               end else begin
                  pc_nxt_s = pc_r;
               end
            end
            ST_TRAP:  pc_nxt_s = pc_r;
            default:  pc_nxt_s = pc_r;
         endcase
      end
   end

   // Registered outputs follow the next state; request stays low for the redirect cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r         <= RESET_PC;
         ir_r         <= 32'h0000_0000;
         cnt_r        <= {CNT_W{1'b0}};
         imem_req_r   <= 1'b0;
         dec_en_r     <= 1'b0;
         trap_valid_r <= 1'b0;
         trap_cause_r <= 2'b00;
         trap_pc_r    <= 32'h0000_0000;
      end else begin
         pc_r         <= pc_nxt_s;
         ir_r         <= ir_nxt_s;
         cnt_r        <= cnt_nxt_s;
         imem_req_r   <= (state_nxt_s == ST_FETCH) && !redirect_valid;
         dec_en_r     <= (state_nxt_s == ST_DECODE);
         trap_valid_r <= (state_nxt_s == ST_TRAP);
         trap_cause_r <= trap_cause_nxt_s;
         trap_pc_r    <= trap_pc_nxt_s;
      end
   end

   assign imem_req   = imem_req_r;
   assign imem_addr  = pc_r;
   assign dec_en     = dec_en_r;
   assign instr_out  = ir_r;
   assign pc_out     = pc_r;
   assign trap_valid = trap_valid_r;
   assign trap_cause = trap_cause_r;
   assign trap_pc    = trap_pc_r;

endmodule
